// File: rtl/mema_stream_ctrl.sv
// mema_stream_ctrl: master-side controller for an 8x8 single-port memory.
// Captures a burst of DEPTH bytes from a valid/ready input stream into the
// memory at consecutive addresses, then reads them back and emits them on a
// valid/ready output stream.
//
// Optional build macro: MEMA_CTRL_REVERSE_EN
//   defined   -> last-in-first-out drain (read pointer DEPTH-1 down to 0)
//   undefined -> first-in-first-out drain (read pointer 0 up to DEPTH-1)
//
// Read timing: the memory's dOut1 is registered, so each output byte costs
// one address cycle (RD_REQ) plus one data cycle (RD_DATA). The address is
// held through RD_DATA so dOut1 stays stable under output backpressure.
// DEPTH must equal 2**AW; the write pointer wraps naturally at that size.

module mema_stream_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic [AW-1:0] addrA,
    output logic          weA,
    output logic [DW-1:0] datainA,
    input  logic [DW-1:0] dOut1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_e;

    // Count value held while the final byte of a burst is being accepted.
    localparam logic [AW:0] LAST_COUNT = (AW+1)'(DEPTH - 1);

`ifdef MEMA_CTRL_REVERSE_EN
    // LIFO drain: start at the top address and walk down to 0.
    localparam logic [AW-1:0] RD_FIRST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] RD_LAST  = '0;
`else
    // FIFO drain: start at address 0 and walk up to the top address.
    localparam logic [AW-1:0] RD_FIRST = '0;
    localparam logic [AW-1:0] RD_LAST  = AW'(DEPTH - 1);
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_next;

    // Step the read pointer in the drain direction selected at build time.
    always_comb begin
`ifdef MEMA_CTRL_REVERSE_EN
        rd_ptr_next = rd_ptr_q - AW'(1);
`else
        rd_ptr_next = rd_ptr_q + AW'(1);
`endif
    end

    // State register, pointers and byte count; reset aborts a burst at once.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic and all state-decoded outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        addrA     = '0;
        weA       = 1'b0;
        datainA   = '0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // in_valid is deliberately ignored until the burst starts.
                if (start) begin
                    state_d  = S_FILL;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end
            end

            S_FILL: begin
                // Write-through: the memory write happens in the same cycle
                // as the input handshake, so weA follows in_valid directly.
                in_ready = 1'b1;
                weA      = in_valid;
                addrA    = wr_ptr_q;
                datainA  = in_data;
                if (in_valid) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + (AW+1)'(1);
                    if (count_q == LAST_COUNT) begin
                        state_d  = S_RD_REQ;
                        rd_ptr_d = RD_FIRST;
                    end
                end
            end

            S_RD_REQ: begin
                // Present the read address; dOut1 is valid next cycle.
                addrA   = rd_ptr_q;
                state_d = S_RD_DATA;
            end

            S_RD_DATA: begin
                // Address stays put so the registered read data is stable
                // for as long as the consumer stalls.
                addrA     = rd_ptr_q;
                out_valid = 1'b1;
                out_data  = dOut1;
                if (out_ready) begin
                    if (rd_ptr_q == RD_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_next;
                        state_d  = S_RD_REQ;
                    end
                end
            end

            S_DONE: begin
                // start is ignored here too; count keeps DEPTH until restart.
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign count = count_q;

endmodule

// File: tb/tb_mema_stream_ctrl.sv
// Self-checking bench for mema_stream_ctrl with a behavioural 8x8 memory
// (registered read, write when weA=1). Directed scenarios: reset, FIFO order
// and throughput, input gaps, output backpressure, start while busy, async
// reset mid-drain followed by a fresh burst, and drain order under the
// MEMA_CTRL_REVERSE_EN build.

module tb_mema_stream_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef logic [7:0] burst_t [8];

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [AW-1:0] addrA;
    logic          weA;
    logic [DW-1:0] datainA;
    logic [DW-1:0] dOut1     = '0;
    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_wr_cyc = 0;

    logic [2:0] we_addr [$];
    logic       fc_valid [$];
    logic       fc_we [$];
    logic [3:0] fc_count [$];
    logic [7:0] od_data [$];
    logic [2:0] od_addr [$];
    int         od_cyc [$];
    logic [7:0] st_data [$];
    logic [2:0] st_addr [$];
    logic       st_valid [$];

    mema_stream_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .addrA     (addrA),
        .weA       (weA),
        .datainA   (datainA),
        .dOut1     (dOut1)
    );

    always #5 clock = ~clock;

    // Single-port memory with registered read data.
    always @(posedge clock) begin
        if (weA) mem[addrA] <= datainA;
        else     dOut1 <= mem[addrA];
    end

    always @(posedge clock) cyc++;

    // Monitors sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (weA === 1'b1) we_addr.push_back(addrA);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Index of the filled byte expected as the i-th output.
    function automatic int rd_idx(input int i);
`ifdef MEMA_CTRL_REVERSE_EN
        return DEPTH - 1 - i;
`else
        return i;
`endif
    endfunction

    task automatic kick();
        @(posedge clock); #1;
        start = 1'b1;
    endtask

    task automatic fill(input burst_t d, input bit gaps, input bit poke);
        int idx = 0;
        int t = 0;
        bit ph = 1'b1;
        fc_valid.delete(); fc_we.delete(); fc_count.delete();
        while (idx < DEPTH && t < 64) begin
            @(posedge clock); #1;
            start    = poke && (t == 3);
            in_valid = gaps ? ph : 1'b1;
            in_data  = in_valid ? d[idx] : 8'h5A;
            ph = ~ph;
            @(negedge clock);
            fc_valid.push_back(in_valid);
            fc_we.push_back(weA);
            fc_count.push_back(count);
            if (in_valid && in_ready) begin
                idx++;
                last_wr_cyc = cyc;
            end
            t++;
        end
        n_cmp++;
        if (idx !== DEPTH) begin
            n_bad++;
            $display("FAIL fill_accepted: got %0d bytes, required %0d", idx, DEPTH);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic drain(input int n_max, input int stall_at, input int stall_len, input bit poke);
        int n = 0;
        int t = 0;
        int stalled = 0;
        od_data.delete(); od_addr.delete(); od_cyc.delete();
        st_data.delete(); st_addr.delete(); st_valid.delete();
        while (n < n_max && t < 200) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (out_valid && n == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                if (poke && stalled == 2) start = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clock);
            if (!out_ready) begin
                st_data.push_back(out_data);
                st_addr.push_back(addrA);
                st_valid.push_back(out_valid);
            end
            if (out_valid && out_ready) begin
                od_data.push_back(out_data);
                od_addr.push_back(addrA);
                od_cyc.push_back(cyc);
                n++;
            end
            t++;
        end
        n_cmp++;
        if (n !== n_max) begin
            n_bad++;
            $display("FAIL drain_handshakes: got %0d bytes, required %0d", n, n_max);
        end
        @(posedge clock); #1;
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({in_ready, out_valid, out_data, busy, done, count, addrA, weA, datainA} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {in_ready, out_valid, out_data, busy, done, count, addrA, weA, datainA});
        end
        #21;
        reset = 1'b0;
        @(negedge clock); #1;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_fifo_order();
        burst_t d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int base = done_cnt;
        we_addr.delete();
        kick();
        fill(d, 1'b0, 1'b0);
        drain(DEPTH, 99, 0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        n_cmp++;
        if (we_addr.size() !== DEPTH) begin
            n_bad++;
            $display("FAIL fifo_we_cycles: got %0d, required %0d", we_addr.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (we_addr[i] !== 3'(i)) begin
                n_bad++;
                $display("FAIL fifo_we_addr[%0d]: got %0d, required %0d", i, we_addr[i], i);
            end
            n_cmp++;
            if (od_data[i] !== d[rd_idx(i)] || od_addr[i] !== 3'(rd_idx(i))) begin
                n_bad++;
                $display("FAIL fifo_out[%0d]: got data %h addr %0d, required data %h addr %0d",
                         i, od_data[i], od_addr[i], d[rd_idx(i)], rd_idx(i));
            end
        end
        n_cmp++;
        if (od_cyc[0] - last_wr_cyc !== 2) begin
            n_bad++;
            $display("FAIL fifo_first_latency: got %0d cycles, required 2", od_cyc[0] - last_wr_cyc);
        end
        for (int i = 1; i < DEPTH; i++) begin
            n_cmp++;
            if (od_cyc[i] - od_cyc[i-1] !== 2) begin
                n_bad++;
                $display("FAIL fifo_spacing[%0d]: got %0d cycles, required 2", i, od_cyc[i] - od_cyc[i-1]);
            end
        end
        n_cmp++;
        if (done_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL fifo_done_pulses: got %0d, required 1", done_cnt - base);
        end
        n_cmp++;
        if (count !== 4'd8 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fifo_final: count=%0d busy=%b, required 8 0", count, busy);
        end
    endtask

    task automatic test_gaps();
        burst_t d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        int acc = 0;
        kick();
        fill(d, 1'b1, 1'b0);
        for (int j = 0; j < fc_valid.size(); j++) begin
            n_cmp++;
            if (fc_we[j] !== fc_valid[j] || fc_count[j] !== 4'(acc)) begin
                n_bad++;
                $display("FAIL gaps_cycle[%0d]: got weA=%b count=%0d, required weA=%b count=%0d",
                         j, fc_we[j], fc_count[j], fc_valid[j], acc);
            end
            if (fc_valid[j]) acc++;
        end
        drain(DEPTH, 99, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (od_data[i] !== d[rd_idx(i)]) begin
                n_bad++;
                $display("FAIL gaps_out[%0d]: got %h, required %h", i, od_data[i], d[rd_idx(i)]);
            end
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_backpressure();
        burst_t d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        kick();
        fill(d, 1'b0, 1'b0);
        drain(DEPTH, 2, 5, 1'b0);
        n_cmp++;
        if (st_data.size() !== 5) begin
            n_bad++;
            $display("FAIL bp_stall_cycles: got %0d, required 5", st_data.size());
        end
        for (int k = 0; k < st_data.size(); k++) begin
            n_cmp++;
            if (st_valid[k] !== 1'b1 || st_data[k] !== d[rd_idx(2)] || st_addr[k] !== 3'(rd_idx(2))) begin
                n_bad++;
                $display("FAIL bp_stall[%0d]: got valid=%b data=%h addr=%0d, required 1 %h %0d",
                         k, st_valid[k], st_data[k], st_addr[k], d[rd_idx(2)], rd_idx(2));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (od_data[i] !== d[rd_idx(i)]) begin
                n_bad++;
                $display("FAIL bp_out[%0d]: got %h, required %h", i, od_data[i], d[rd_idx(i)]);
            end
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_start_while_busy();
        burst_t d = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
        int base = done_cnt;
        we_addr.delete();
        kick();
        fill(d, 1'b0, 1'b1);
        drain(DEPTH, 1, 2, 1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (od_data[i] !== d[rd_idx(i)]) begin
                n_bad++;
                $display("FAIL swb_out[%0d]: got %h, required %h", i, od_data[i], d[rd_idx(i)]);
            end
        end
        n_cmp++;
        if (done_cnt - base !== 1 || we_addr.size() !== DEPTH) begin
            n_bad++;
            $display("FAIL swb_counts: got done=%0d writes=%0d, required 1 %0d",
                     done_cnt - base, we_addr.size(), DEPTH);
        end
        n_cmp++;
        if (busy !== 1'b0 || count !== 4'd8) begin
            n_bad++;
            $display("FAIL swb_idle: busy=%b count=%0d, required 0 8", busy, count);
        end
    endtask

    task automatic test_reset_mid_drain();
        burst_t d1 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        burst_t d2 = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
        int base;
        kick();
        fill(d1, 1'b0, 1'b0);
        drain(3, 99, 0, 1'b0);
        @(posedge clock); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || addrA !== 3'(rd_idx(3))) begin
            n_bad++;
            $display("FAIL rst_pre: out_valid=%b addrA=%0d, required 1 %0d", out_valid, addrA, rd_idx(3));
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_data, busy, done, count, addrA, weA, datainA} !== 28'h0) begin
            n_bad++;
            $display("FAIL rst_async_outputs: got %h, required 0",
                     {in_ready, out_valid, out_data, busy, done, count, addrA, weA, datainA});
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        base = done_cnt;
        kick();
        fill(d2, 1'b0, 1'b0);
        drain(DEPTH, 99, 0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (od_data[i] !== d2[rd_idx(i)]) begin
                n_bad++;
                $display("FAIL rst_reburst[%0d]: got %h, required %h", i, od_data[i], d2[rd_idx(i)]);
            end
        end
        n_cmp++;
        if (done_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL rst_reburst_done: got %0d, required 1", done_cnt - base);
        end
    endtask

    task automatic test_drain_order();
        burst_t d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        kick();
        fill(d, 1'b0, 1'b0);
        drain(DEPTH, 99, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (od_data[i] !== d[rd_idx(i)] || od_addr[i] !== 3'(rd_idx(i))) begin
                n_bad++;
                $display("FAIL order_out[%0d]: got data %h addr %0d, required data %h addr %0d",
                         i, od_data[i], od_addr[i], d[rd_idx(i)], rd_idx(i));
            end
        end
        repeat (3) @(posedge clock);
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_gaps();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_drain();
        test_drain_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mema_stream_ctrl.md
Name: mema_stream_ctrl

Overview:
- Master-side controller for the 8x8 single-port memory block.
- Accepts a burst of DEPTH bytes on a valid/ready input stream and writes them into the memory at consecutive addresses.
- Then reads them back and emits them on a valid/ready output stream.
- Sits between a byte producer and consumer, and owns the memory's address, write-enable and write-data pins.

Parameters:
- DW, 8, data width in bits.
- AW, 3, memory address width in bits.
- DEPTH, 8, bytes per burst; must equal 2**AW.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- in_valid  input  1  input byte valid.
- in_data  input  DW  input byte.
- in_ready  output  1  controller accepts in_data this cycle.
- out_valid  output  1  out_data valid.
- out_data  output  DW  byte read back from memory.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final output handshake.
- count  output  AW+1  bytes written in the current burst (0..DEPTH).
- addrA  output  AW  memory address.
- weA  output  1  memory write enable.
- datainA  output  DW  memory write data.
- dOut1  input  DW  memory read data; registered, valid the cycle after a read address is presented with weA=0.

Behaviour:
- Reset (async, active-high) forces state IDLE and clears all outputs: in_ready, out_valid, out_data, busy, done, count, addrA, weA and datainA are all 0. Internal pointers are cleared.
- States: IDLE, FILL, RD_REQ, RD_DATA, DONE.
- IDLE:
  - busy=0, weA=0.
  - start=1 -> FILL next cycle, count cleared to 0, write pointer=0.
  - in_valid is ignored.
- FILL:
  - in_ready=1.
  - weA = in_valid, combinationally. addrA = write pointer. datainA = in_data.
  - Each cycle with in_valid & in_ready writes one byte; write pointer and count each increment by 1.
  - A gap (in_valid=0) holds the pointer and count and keeps weA=0.
  - When the DEPTH-th byte is accepted -> RD_REQ, with read pointer = 0.
  - The pointer wraps from DEPTH-1 to 0 with no overflow flag.
- RD_REQ:
  - weA=0, addrA = read pointer, out_valid=0, in_ready=0.
  - Lasts exactly one cycle -> RD_DATA.
- RD_DATA:
  - addrA is held at the read pointer and weA=0, so dOut1 stays stable.
  - out_valid=1 and out_data = dOut1.
  - out_ready=0: stay, with out_data stable.
  - out_ready=1 and more bytes remain: increment the read pointer -> RD_REQ.
  - out_ready=1 on the last byte -> DONE.
- Throughput: minimum 2 cycles per output byte. First out_valid is 2 cycles after the last FILL write.
- DONE:
  - done=1 and busy=1 for one cycle -> IDLE.
  - count holds DEPTH until the next start.
- Simultaneous events:
  - start outside IDLE is ignored, including in DONE.
  - in_valid outside FILL is never accepted (in_ready=0).
- Reset mid-burst aborts immediately. Memory contents are not cleared by this block. The next burst overwrites them.

Optional Feature:
- Macro: MEMA_CTRL_REVERSE_EN.
- Defined:
  - Drain is last-in-first-out. The read pointer starts at DEPTH-1 and decrements; the final output byte is from address 0.
  - FILL is unchanged.
- Undefined:
  - Drain is first-in-first-out. The read pointer starts at 0 and increments.

Test Plan:
- FIFO order: reset, start, 8 consecutive in_valid bytes 0x11,0x22,...,0x88 with out_ready=1.
  - weA high for exactly 8 cycles at addrA 0..7.
  - out_data sequence 0x11..0x88, one byte every 2 cycles.
  - done pulses once; count=8.
- Input gaps: in_valid toggled 1,0,1,0... with bytes 0xA0..0xA7.
  - weA low on gap cycles; count advances only on accepted bytes.
  - Readback is 0xA0..0xA7.
- Backpressure: hold out_ready=0 for 5 cycles on the third output byte.
  - out_valid stays 1; out_data and addrA=2 stay stable.
  - Resumes correctly when out_ready rises.
- Start while busy: pulse start during FILL and during RD_DATA.
  - No state or pointer change; exactly one done pulse per burst.
- Async reset in RD_DATA after 3 outputs.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - A following burst with 0xF0..0xF7 reads back 0xF0..0xF7.
- With MEMA_CTRL_REVERSE_EN defined: fill 0x01..0x08.
  - Output sequence 0x08..0x01; addrA read order 7..0.
